spmmio_wb_master: RTL and testbench
===================================

# spmmio_wb_master

Bus master feeding the soft-CPU I/O window into the spmmio Wishbone slave. It accepts one word request at a time from the CPU's native request/ready bus and runs exactly one classic Wishbone cycle per request. It guards every cycle with a timeout watchdog, so an unmapped or stuck peripheral returns an error instead of hanging the CPU. It sits directly upstream of the spmmio decoder: `adr_o`/`stb_o`/`cyc_o`/`sel_o`/`we_o`/`dat_o` connect to its slave inputs.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 64: cycles in BUS without `ack_i` before the access is aborted; legal range 2..255.
- `ERR_DATA`, default 32'hFFFFFFFF: read data returned on error.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-low reset.
- `cpu_req` in 1: request valid; held until `cpu_ready`.
- `cpu_we` in 1: 1 = write.
- `cpu_adr` in [0:23]: byte address; bits 22–23 must be 0.
- `cpu_sel` in [0:3]: byte lane enables, bit 0 = MSB lane.
- `cpu_wdata` in [0:31]: write data.
- `cpu_ready` out 1: one-cycle completion pulse.
- `cpu_rdata` out [0:31]: read data; valid while `cpu_ready`.
- `cpu_err` out 1: completion was an error; valid while `cpu_ready`.
- `adr_o` out [0:23], `sel_o` out [0:3], `we_o` out 1, `dat_o` out [0:31]: Wishbone request fields.
- `cyc_o` out 1, `stb_o` out 1: Wishbone cycle and strobe, always equal.
- `ack_i` in 1, `dat_i` in [0:31]: Wishbone response; `ack_i` may be combinational from `stb_o`.
- `err_count` out [0:7]: saturating count of error completions.
- `last_err_adr` out [0:23]: `cpu_adr` of the most recent error.

## Operation
- States:
  - IDLE: waiting for a request.
  - BUS: Wishbone cycle in progress.
  - RESP: completion is being reported to the CPU.
- IDLE, `cpu_req`=1:
  - Latch `cpu_adr`, `cpu_sel`, `cpu_we` and `cpu_wdata` into the output registers.
  - Misaligned address (`cpu_adr[22:23]` ≠ 0) or `cpu_sel`=0 → RESP with error; no bus cycle is started.
  - Otherwise → BUS with `cyc_o`=`stb_o`=1 and the timeout counter cleared.
- BUS:
  - `ack_i`=1 → RESP, no error. On a read, capture `dat_i` into `cpu_rdata`; on a write, `cpu_rdata` = 0.
  - Otherwise the counter increments. When the counter equals `TIMEOUT_CYCLES`-1 and `ack_i`=0 → RESP with error.
  - `ack_i` arriving on the timeout cycle wins: the access completes normally.
- RESP:
  - `cpu_ready`=1 for exactly one cycle; `cyc_o`=`stb_o`=0.
  - On error: `cpu_err`=1, `cpu_rdata`=`ERR_DATA`, `err_count` += 1 (saturates at 255), `last_err_adr` updated.
  - Always returns to IDLE.
- `cpu_req` dropping while in BUS is a protocol violation; the cycle still completes.
- `adr_o`, `sel_o`, `we_o` and `dat_o` hold their values outside BUS.

## Timing
- All outputs are registered.
- Reset values: state IDLE, `cyc_o`=`stb_o`=0, `we_o`=0, `adr_o`=0, `sel_o`=0, `dat_o`=0, `cpu_ready`=0, `cpu_err`=0, `cpu_rdata`=0, `err_count`=0, `last_err_adr`=0, timeout counter 0.
- Zero-wait slave: request sampled at edge N; `stb_o` high in cycle N+1 with `ack_i` in the same cycle; `cpu_ready` high in cycle N+2. Latency is 2 cycles.
- Throughput: one access per 3 cycles. IDLE ignores `cpu_req` during the RESP cycle, so a request held past `cpu_ready` is not re-executed.
- Misaligned request: `cpu_ready` with error at N+1; `cyc_o` never asserts.
- Timeout: `stb_o` stays high for exactly `TIMEOUT_CYCLES` cycles; `cpu_ready` follows on the next cycle.
- Reset asserted mid-BUS: `cyc_o`/`stb_o` are low after that edge; no `cpu_ready` is produced.

## Structure
- Shared defines file `spmmio_defs.vh` holds:
  - state encoding (IDLE=2'd0, BUS=2'd1, RESP=2'd2);
  - the default timeout;
  - the default `ERR_DATA`.
- Optional sub-module `spmmio_wdog`: the timeout counter with clear/enable inputs and an expire output. Everything else stays flat.

## Test plan
- Read with combinational-ack slave at `cpu_adr`=24'h000004, `dat_i`=32'h12345678 → `stb_o` high 1 cycle; `cpu_ready` 2 cycles after request; `cpu_rdata`=32'h12345678; `cpu_err`=0.
- Write `cpu_adr`=24'h020000, `cpu_sel`=4'b0011, data 32'hCAFEBABE → `adr_o`/`sel_o`/`we_o`/`dat_o` match during `stb_o`; `cpu_ready` with `cpu_err`=0; `cpu_rdata`=0.
- Slave that never acks, `TIMEOUT_CYCLES`=64 → `stb_o` high 64 cycles; `cpu_err`=1; `cpu_rdata`=32'hFFFFFFFF; `err_count`=1; `last_err_adr` = request address.
- Misaligned `cpu_adr`=24'h000002 → `cpu_ready`+`cpu_err` at N+1; `cyc_o` stays 0; `err_count` increments.
- Ack on timeout cycle 63 → normal completion, `cpu_err`=0; then 256 misaligned errors → `err_count` saturates at 8'hFF.
- Reset pulled low during BUS in a wait-state access → next cycle `cyc_o`=0, `cpu_ready`=0, state IDLE; the following request completes normally.

Source files
------------

// File: rtl/spmmio_wb_master_pkg.sv
// Shared types and constants for the spmmio Wishbone bus master.
// Holds the FSM state encoding, the default timeout and error read data,
// the latched request record and the saturating error-counter helper.
package spmmio_wb_master_pkg;

    // FSM state encoding shared by the master and anything that probes it
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int          DEFAULT_TIMEOUT  = 64;
    localparam logic [31:0] DEFAULT_ERR_DATA = 32'hFFFFFFFF;

    // Timeout counter width; wide enough for any legal TIMEOUT_CYCLES (2..255)
    localparam int CNT_W = 8;

    // Request fields captured from the CPU and driven onto the Wishbone bus
    typedef struct packed {
        logic        we;
        logic [0:23] adr;
        logic [0:3]  sel;
        logic [0:31] data;
    } wb_req_t;

    // Error counter sticks at its maximum instead of wrapping
    function automatic logic [0:7] satInc(input logic [0:7] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/spmmio_wb_master_wdog.sv
// Timeout watchdog for the spmmio Wishbone master.
// Counts bus cycles that pass without an acknowledge.
// Ports:
//   clk, reset  - system clock, synchronous active-low reset
//   clear_i     - force the count back to zero
//   enable_i    - advance the count by one this cycle
//   expire_o    - count has reached LIMIT-1 (the last cycle allowed)
module spmmio_wdog
    import spmmio_wb_master_pkg::*;
#(
    parameter int LIMIT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    logic [CNT_W-1:0] count_q;

    // Clear wins over enable so a fresh access always starts from zero
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (enable_i) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expire_o = (count_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/spmmio_wb_master.sv
// Bus master bridging the soft-CPU request/ready I/O port to the spmmio
// Wishbone slave. One classic Wishbone cycle per CPU request, guarded by a
// timeout watchdog so a missing peripheral reports an error.
// Ports:
//   clk, reset                  - system clock, synchronous active-low reset
//   cpu_req/we/adr/sel/wdata    - CPU request (held until cpu_ready)
//   cpu_ready/rdata/err         - one-cycle completion with read data / error
//   adr_o/sel_o/we_o/dat_o      - Wishbone request fields (held outside BUS)
//   cyc_o/stb_o                 - Wishbone cycle / strobe (always equal)
//   ack_i/dat_i                 - Wishbone response
//   err_count/last_err_adr      - saturating error count, address of last error
module spmmio_wb_master
    import spmmio_wb_master_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
    parameter logic [0:31] ERR_DATA       = DEFAULT_ERR_DATA
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [0:23] cpu_adr,
    input  logic [0:3]  cpu_sel,
    input  logic [0:31] cpu_wdata,
    output logic        cpu_ready,
    output logic [0:31] cpu_rdata,
    output logic        cpu_err,
    output logic [0:23] adr_o,
    output logic [0:3]  sel_o,
    output logic        we_o,
    output logic [0:31] dat_o,
    output logic        cyc_o,
    output logic        stb_o,
    input  logic        ack_i,
    input  logic [0:31] dat_i,
    output logic [0:7]  err_count,
    output logic [0:23] last_err_adr
);

    state_e      state_q, state_d;
    wb_req_t     req_q, req_d;
    logic        stb_q, stb_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;
    logic [0:31] rdata_q, rdata_d;
    logic [0:7]  errCount_q, errCount_d;
    logic [0:23] lastErrAdr_q, lastErrAdr_d;

    logic wdClear, wdEnable, wdExpire;

    spmmio_wdog #(
        .LIMIT(TIMEOUT_CYCLES)
    ) uWdog (
        .clk     (clk),
        .reset   (reset),
        .clear_i (wdClear),
        .enable_i(wdEnable),
        .expire_o(wdExpire)
    );

    // State and every output are registered; next values come from below
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            req_q        <= '0;
            stb_q        <= 1'b0;
            ready_q      <= 1'b0;
            err_q        <= 1'b0;
            rdata_q      <= '0;
            errCount_q   <= '0;
            lastErrAdr_q <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            stb_q        <= stb_d;
            ready_q      <= ready_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
            errCount_q   <= errCount_d;
            lastErrAdr_q <= lastErrAdr_d;
        end
    end

    // Next-state and next-output logic. The watchdog is held clear outside a
    // bus cycle, so it reads zero on the first BUS cycle. RESP never looks at
    // cpu_req, which keeps a request held across cpu_ready from re-running.
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        stb_d        = 1'b0;
        ready_d      = 1'b0;
        err_d        = 1'b0;
        rdata_d      = rdata_q;
        errCount_d   = errCount_q;
        lastErrAdr_d = lastErrAdr_q;
        wdClear      = 1'b0;
        wdEnable     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                wdClear = 1'b1;
                if (cpu_req) begin
                    req_d = '{we: cpu_we, adr: cpu_adr, sel: cpu_sel, data: cpu_wdata};
                    if ((cpu_adr[22:23] != 2'b00) || (cpu_sel == 4'b0000)) begin
                        state_d      = ST_RESP;
                        ready_d      = 1'b1;
                        err_d        = 1'b1;
                        rdata_d      = ERR_DATA;
                        errCount_d   = satInc(errCount_q);
                        lastErrAdr_d = cpu_adr;
                    end else begin
                        state_d = ST_BUS;
                        stb_d   = 1'b1;
                    end
                end
            end

            ST_BUS: begin
                if (ack_i) begin
                    state_d = ST_RESP;
                    ready_d = 1'b1;
                    rdata_d = req_q.we ? '0 : dat_i;
                end else if (wdExpire) begin
                    state_d      = ST_RESP;
                    ready_d      = 1'b1;
                    err_d        = 1'b1;
                    rdata_d      = ERR_DATA;
                    errCount_d   = satInc(errCount_q);
                    lastErrAdr_d = req_q.adr;
                end else begin
                    stb_d    = 1'b1;
                    wdEnable = 1'b1;
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign adr_o        = req_q.adr;
    assign sel_o        = req_q.sel;
    assign we_o         = req_q.we;
    assign dat_o        = req_q.data;
    assign cyc_o        = stb_q;
    assign stb_o        = stb_q;
    assign cpu_ready    = ready_q;
    assign cpu_err      = err_q;
    assign cpu_rdata    = rdata_q;
    assign err_count    = errCount_q;
    assign last_err_adr = lastErrAdr_q;

endmodule

// File: tb/tb_spmmio_wb_master.sv
// Self-checking bench for spmmio_wb_master: fixed vector table, randomized
// accesses against a behavioural reference model, and hand-written sequences
// for timeout, ack-on-last-cycle, reset during a bus cycle and saturation.
module tb_spmmio_wb_master;

    localparam int          TO   = 64;
    localparam logic [31:0] ERRD = 32'hFFFFFFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [0:23] cpu_adr;
    logic [0:3]  cpu_sel;
    logic [0:31] cpu_wdata;
    logic        cpu_ready;
    logic [0:31] cpu_rdata;
    logic        cpu_err;
    logic [0:23] adr_o;
    logic [0:3]  sel_o;
    logic        we_o;
    logic [0:31] dat_o;
    logic        cyc_o;
    logic        stb_o;
    logic        ack_i;
    logic [0:31] dat_i;
    logic [0:7]  err_count;
    logic [0:23] last_err_adr;

    int          ackWait   = 0;
    int          stbCnt    = 0;
    logic [31:0] slaveData = '0;

    int          nChecks = 0;
    int          nFail   = 0;
    int          modelErrCount = 0;
    logic [23:0] modelLastErr  = '0;

    typedef struct {
        logic        we;
        logic [23:0] adr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        int          waitCyc;
        logic [31:0] sdata;
        logic        expErr;
        logic [31:0] expRdata;
        int          expLat;
        int          expStb;
    } vec_t;

    vec_t vecs[7];

    spmmio_wb_master #(
        .TIMEOUT_CYCLES(TO),
        .ERR_DATA      (ERRD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_adr     (cpu_adr),
        .cpu_sel     (cpu_sel),
        .cpu_wdata   (cpu_wdata),
        .cpu_ready   (cpu_ready),
        .cpu_rdata   (cpu_rdata),
        .cpu_err     (cpu_err),
        .adr_o       (adr_o),
        .sel_o       (sel_o),
        .we_o        (we_o),
        .dat_o       (dat_o),
        .cyc_o       (cyc_o),
        .stb_o       (stb_o),
        .ack_i       (ack_i),
        .dat_i       (dat_i),
        .err_count   (err_count),
        .last_err_adr(last_err_adr)
    );

    always #5 clk = ~clk;

    // Slave: acks (combinationally) on the ackWait-th cycle of a strobe run,
    // never when ackWait is negative
    always @(posedge clk) stbCnt <= stb_o ? stbCnt + 1 : 0;
    assign ack_i = stb_o && (ackWait >= 0) && (stbCnt == ackWait);
    assign dat_i = slaveData;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: outcome of one access from the access rules alone
    task automatic refModel(input logic we, input logic [23:0] adr, input logic [3:0] sel,
                            input int waitCyc, input logic [31:0] sdata,
                            output logic e, output logic [31:0] rd, output int lat, output int stb);
        if ((adr % 4) != 0 || sel == 0) begin
            e = 1'b1; rd = ERRD; stb = 0; lat = 1;
        end else if (waitCyc >= 0 && waitCyc < TO) begin
            e = 1'b0; rd = we ? 32'h0 : sdata; stb = waitCyc + 1; lat = stb + 1;
        end else begin
            e = 1'b1; rd = ERRD; stb = TO; lat = TO + 1;
        end
    endtask

    // One complete CPU access; request is held through the RESP cycle edge
    task automatic applyStimulus(input logic we, input logic [23:0] adr, input logic [3:0] sel,
                                 input logic [31:0] wd, input int waitCyc, input logic [31:0] sdata,
                                 input logic expErr, input logic [31:0] expRd,
                                 input int expLat, input int expStb);
        int cycles  = 0;
        int stbSeen = 0;
        int busBad  = 0;
        bit done    = 1'b0;
        slaveData = sdata;
        ackWait   = waitCyc;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_adr   = adr;
        cpu_sel   = sel;
        cpu_wdata = wd;
        while (!done && cycles < 300) begin
            @(negedge clk);
            cycles++;
            if (stb_o) begin
                stbSeen++;
                if (adr_o !== adr || sel_o !== sel || we_o !== we || dat_o !== wd || cyc_o !== 1'b1)
                    busBad++;
            end
            if (cpu_ready) done = 1'b1;
        end
        checkOutput("ready_seen", 64'(done), 64'd1);
        if (done) begin
            checkOutput("latency", 64'(cycles), 64'(expLat));
            checkOutput("stb_cycles", 64'(stbSeen), 64'(expStb));
            checkOutput("bus_fields", 64'(busBad), 64'd0);
            checkOutput("cpu_err", 64'(cpu_err), 64'(expErr));
            checkOutput("cpu_rdata", 64'(cpu_rdata), 64'(expRd));
            checkOutput("adr_hold", 64'(adr_o), 64'(adr));
            checkOutput("sel_hold", 64'(sel_o), 64'(sel));
            checkOutput("cyc_in_resp", 64'(cyc_o), 64'd0);
        end
        if (expErr) begin
            modelErrCount = (modelErrCount < 255) ? modelErrCount + 1 : 255;
            modelLastErr  = adr;
        end
        @(negedge clk);
        cpu_req = 1'b0;
        checkOutput("ready_pulse", 64'(cpu_ready), 64'd0);
        checkOutput("no_rerun", 64'(cyc_o), 64'd0);
        checkOutput("err_count", 64'(err_count), 64'(modelErrCount));
        checkOutput("last_err_adr", 64'(last_err_adr), 64'(modelLastErr));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout actual=running required=finished");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        logic        e;
        logic [31:0] rd;
        int          lat, stb, quiet;

        vecs[0] = '{1'b0, 24'h000004, 4'hF, 32'h0,        0, 32'h12345678, 1'b0, 32'h12345678, 2, 1};
        vecs[1] = '{1'b1, 24'h020000, 4'h3, 32'hCAFEBABE, 0, 32'hDEADBEEF, 1'b0, 32'h00000000, 2, 1};
        vecs[2] = '{1'b0, 24'h000002, 4'hF, 32'h0,        0, 32'h11111111, 1'b1, 32'hFFFFFFFF, 1, 0};
        vecs[3] = '{1'b1, 24'h000100, 4'h0, 32'h01020304, 0, 32'h22222222, 1'b1, 32'hFFFFFFFF, 1, 0};
        vecs[4] = '{1'b0, 24'h000200, 4'hF, 32'h0,        3, 32'hA5A55A5A, 1'b0, 32'hA5A55A5A, 5, 4};
        vecs[5] = '{1'b1, 24'h3FFFFC, 4'h8, 32'h0BADF00D, 1, 32'h77777777, 1'b0, 32'h00000000, 3, 2};
        vecs[6] = '{1'b0, 24'h000001, 4'h1, 32'h0,        0, 32'h33333333, 1'b1, 32'hFFFFFFFF, 1, 0};

        reset     = 1'b0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_adr   = '0;
        cpu_sel   = '0;
        cpu_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_cyc", 64'(cyc_o), 64'd0);
        checkOutput("rst_stb", 64'(stb_o), 64'd0);
        checkOutput("rst_ready", 64'(cpu_ready), 64'd0);
        checkOutput("rst_err", 64'(cpu_err), 64'd0);
        checkOutput("rst_rdata", 64'(cpu_rdata), 64'd0);
        checkOutput("rst_err_count", 64'(err_count), 64'd0);
        checkOutput("rst_last_err", 64'(last_err_adr), 64'd0);
        checkOutput("rst_adr", 64'(adr_o), 64'd0);
        checkOutput("rst_sel", 64'(sel_o), 64'd0);
        checkOutput("rst_we", 64'(we_o), 64'd0);
        checkOutput("rst_dat", 64'(dat_o), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        foreach (vecs[i])
            applyStimulus(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].wdata, vecs[i].waitCyc,
                          vecs[i].sdata, vecs[i].expErr, vecs[i].expRdata, vecs[i].expLat, vecs[i].expStb);

        for (int n = 0; n < 40; n++) begin
            logic        rwe;
            logic [23:0] radr;
            logic [3:0]  rsel;
            logic [31:0] rwd, rsd;
            int          rwait;
            rwe  = 1'($urandom_range(0, 1));
            radr = 24'($urandom);
            if ($urandom_range(0, 3) != 0) radr[1:0] = 2'b00;
            rsel = 4'($urandom_range(0, 15));
            rwd  = $urandom;
            rsd  = $urandom;
            if ($urandom_range(0, 9) == 0) rwait = -1;
            else rwait = int'($urandom_range(0, 6));
            refModel(rwe, radr, rsel, rwait, rsd, e, rd, lat, stb);
            applyStimulus(rwe, radr, rsel, rwd, rwait, rsd, e, rd, lat, stb);
        end

        // Slave never acks: strobe for TO cycles, then error completion
        applyStimulus(1'b0, 24'h00ABC0, 4'hF, 32'h0, -1, 32'h0, 1'b1, ERRD, TO + 1, TO);
        // Ack on the final allowed cycle beats the timeout
        applyStimulus(1'b0, 24'h001000, 4'hF, 32'h0, TO - 1, 32'h5555AAAA, 1'b0, 32'h5555AAAA, TO + 1, TO);

        // Reset in the middle of a wait-state access
        slaveData = 32'h0;
        ackWait   = -1;
        cpu_req   = 1'b1;
        cpu_we    = 1'b0;
        cpu_adr   = 24'h000040;
        cpu_sel   = 4'hF;
        repeat (5) @(negedge clk);
        checkOutput("midbus_stb_before", 64'(stb_o), 64'd1);
        reset   = 1'b0;
        cpu_req = 1'b0;
        @(negedge clk);
        checkOutput("midbus_cyc", 64'(cyc_o), 64'd0);
        checkOutput("midbus_stb", 64'(stb_o), 64'd0);
        checkOutput("midbus_ready", 64'(cpu_ready), 64'd0);
        checkOutput("midbus_err_count", 64'(err_count), 64'd0);
        reset = 1'b1;
        modelErrCount = 0;
        modelLastErr  = '0;
        quiet = 0;
        repeat (4) begin
            @(negedge clk);
            if (cpu_ready || cyc_o) quiet++;
        end
        checkOutput("post_reset_quiet", 64'(quiet), 64'd0);
        applyStimulus(1'b0, 24'h000044, 4'hF, 32'h0, 2, 32'h0F0F0F0F, 1'b0, 32'h0F0F0F0F, 4, 3);

        // Saturation of the error counter
        for (int k = 0; k < 256; k++)
            applyStimulus(1'b1, 24'(k * 4 + 2), 4'hF, 32'h0, 0, 32'h0, 1'b1, ERRD, 1, 0);
        checkOutput("err_count_sat", 64'(err_count), 64'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
        $finish;
    end

endmodule
